// File: rtl/autoapproach_pkg.sv
// autoapproach_pkg: shared state encoding and DAC command default for the approach loop.
package autoapproach_pkg;
   typedef enum logic [5:0] {
      S_IDLE      = 6'b000001,
      S_FETCH     = 6'b000010,
      S_DAC_WAIT  = 6'b000100,
      S_ADC_WAIT  = 6'b001000,
      S_DETECTED  = 6'b010000,
      S_EXHAUSTED = 6'b100000
   } state_t;
   localparam logic [3:0] DAC_CMD_DEFAULT = 4'b0001;
endpackage

// File: rtl/approach_hit_filter.sv
// approach_hit_filter: signed threshold compare with consecutive-hit confirmation.
// confirmed is combinational: it reports whether the sample being presented completes the run.
module approach_hit_filter #(
   parameter int ADC_WID = 18,
   parameter int CNT_WID = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      sample,
   input  logic                      polarity,
   input  logic signed [ADC_WID-1:0] measurement,
   input  logic signed [ADC_WID-1:0] setpoint,
   input  logic [CNT_WID-1:0]        confirm_count,
   output logic                      confirmed
);
   logic               hit;
   logic [CNT_WID-1:0] hit_count, next_count, target;
   always_comb begin
      hit        = polarity ? (measurement >= setpoint) : (measurement <= setpoint);
      target     = (confirm_count == '0) ? CNT_WID'(1) : confirm_count;
      next_count = hit ? ((&hit_count) ? hit_count : hit_count + CNT_WID'(1)) : '0;
      confirmed  = hit && (next_count >= target);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hit_count <= '0;
      else if (clear) hit_count <= '0;
      else if (sample) hit_count <= next_count;
endmodule

// File: rtl/autoapproach_loop.sv
// autoapproach_loop: steps a waveform into a DAC, measures after each step and stops on
// a confirmed threshold crossing or after a bounded number of waveform passes.
module autoapproach_loop
   import autoapproach_pkg::*;
#(
   parameter int         DAC_DATA_WID = 20,
   parameter int         DAC_WID      = 24,
   parameter int         ADC_WID      = 18,
   parameter int         CNT_WID      = 16,
   parameter logic [3:0] DAC_CMD      = DAC_CMD_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      arm,
   input  logic                      polarity,
   input  logic signed [ADC_WID-1:0] setpoint,
   input  logic [CNT_WID-1:0]        confirm_count,
   input  logic [CNT_WID-1:0]        max_loops,
   input  logic [DAC_DATA_WID-1:0]   word,
   input  logic                      word_ok,
   input  logic                      word_last,
   output logic                      word_next,
   output logic                      word_rst,
   output logic                      dac_arm,
   output logic [DAC_WID-1:0]        dac_out,
   input  logic                      dac_finished,
   output logic                      adc_arm,
   input  logic                      adc_finished,
   input  logic signed [ADC_WID-1:0] measurement,
   output logic                      stopped,
   output logic                      detected,
   output logic                      exhausted,
   output logic [CNT_WID-1:0]        step_count,
   output logic [CNT_WID-1:0]        loop_count,
   output logic signed [ADC_WID-1:0] last_meas
);
   state_t                    state;
   logic signed [ADC_WID-1:0] sp_q;
   logic [CNT_WID-1:0]        confirm_q, max_q, step_inc, loop_inc;
   logic                      pol_q, last_q, confirmed;
   always_comb begin
      step_inc = (&step_count) ? step_count : step_count + CNT_WID'(1);
      loop_inc = (&loop_count) ? loop_count : loop_count + CNT_WID'(1);
   end
   approach_hit_filter #(.ADC_WID(ADC_WID), .CNT_WID(CNT_WID)) u_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (state == S_IDLE),
      .sample       ((state == S_ADC_WAIT) && adc_finished && arm),
      .polarity     (pol_q),
      .measurement  (measurement),
      .setpoint     (sp_q),
      .confirm_count(confirm_q),
      .confirmed    (confirmed)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= S_IDLE;
         stopped    <= 1'b1;
         word_rst   <= 1'b1;
         word_next  <= 1'b0;
         dac_arm    <= 1'b0;
         adc_arm    <= 1'b0;
         dac_out    <= '0;
         detected   <= 1'b0;
         exhausted  <= 1'b0;
         step_count <= '0;
         loop_count <= '0;
         last_meas  <= '0;
         sp_q       <= '0;
         confirm_q  <= '0;
         max_q      <= '0;
         pol_q      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (arm) begin
               state      <= S_FETCH;
               word_next  <= 1'b1;
               stopped    <= 1'b0;
               word_rst   <= 1'b0;
               step_count <= '0;
               loop_count <= '0;
               sp_q       <= setpoint;
               confirm_q  <= confirm_count;
               max_q      <= max_loops;
               pol_q      <= polarity;
            end
            S_FETCH: begin
               word_rst <= 1'b0;
               if (!arm) begin
                  state     <= S_IDLE;
                  word_next <= 1'b0;
                  stopped   <= 1'b1;
                  word_rst  <= 1'b1;
               end else if (word_ok) begin
                  state     <= S_DAC_WAIT;
                  word_next <= 1'b0;
                  dac_out   <= {DAC_CMD, word};
                  dac_arm   <= 1'b1;
                  last_q    <= word_last;
               end
            end
            S_DAC_WAIT: if (dac_finished) begin
               dac_arm    <= 1'b0;
               step_count <= step_inc;
               if (!arm) begin
                  state    <= S_IDLE;
                  stopped  <= 1'b1;
                  word_rst <= 1'b1;
               end else begin
                  state   <= S_ADC_WAIT;
                  adc_arm <= 1'b1;
               end
            end
            S_ADC_WAIT: if (adc_finished) begin
               adc_arm   <= 1'b0;
               last_meas <= measurement;
               if (!arm) begin
                  state    <= S_IDLE;
                  stopped  <= 1'b1;
                  word_rst <= 1'b1;
               end else if (confirmed) begin
                  state    <= S_DETECTED;
                  detected <= 1'b1;
               end else if (!last_q) begin
                  state     <= S_FETCH;
                  word_next <= 1'b1;
               end else begin
                  // end of pass: rewind the source and either stop or start the next pass
                  loop_count <= loop_inc;
                  step_count <= '0;
                  word_rst   <= 1'b1;
                  if (max_q != '0 && loop_inc == max_q) begin
                     state     <= S_EXHAUSTED;
                     exhausted <= 1'b1;
                  end else begin
                     state     <= S_FETCH;
                     word_next <= 1'b1;
                  end
               end
            end
            S_DETECTED, S_EXHAUSTED: begin
               word_rst <= 1'b0;
               if (!arm) begin
                  state     <= S_IDLE;
                  detected  <= 1'b0;
                  exhausted <= 1'b0;
                  stopped   <= 1'b1;
                  word_rst  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               stopped   <= 1'b1;
               word_rst  <= 1'b1;
               word_next <= 1'b0;
               dac_arm   <= 1'b0;
               adc_arm   <= 1'b0;
               detected  <= 1'b0;
               exhausted <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_autoapproach_loop.sv
// tb_autoapproach_loop: vector table of approach runs plus hand sequences for abort and reset.
module tb_autoapproach_loop;
   localparam int DW = 20, AW = 18, CW = 16;
   localparam logic [DW-1:0] WBASE = 20'h1A000;
   logic clk = 1'b0, rst_n = 1'b1, arm = 1'b0, polarity = 1'b0;
   logic signed [AW-1:0] setpoint = '0, measurement = '0, last_meas;
   logic [CW-1:0] confirm_count = '0, max_loops = '0, step_count, loop_count;
   logic [DW-1:0] word = '0;
   logic word_ok = 1'b0, word_last = 1'b0, word_next, word_rst;
   logic dac_arm, dac_finished = 1'b0, adc_arm, adc_finished = 1'b0;
   logic [DW+3:0] dac_out;
   logic stopped, detected, exhausted;
   int checks = 0, errors = 0;
   int widx = 0, nwords = 8;
   int dac_rises = 0, adc_rises = 0, rst_pulses = 0, overlaps = 0;
   logic [DW+3:0] exp_dac[$];
   always #5 clk = ~clk;
   autoapproach_loop dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .polarity(polarity), .setpoint(setpoint),
      .confirm_count(confirm_count), .max_loops(max_loops), .word(word), .word_ok(word_ok),
      .word_last(word_last), .word_next(word_next), .word_rst(word_rst), .dac_arm(dac_arm),
      .dac_out(dac_out), .dac_finished(dac_finished), .adc_arm(adc_arm),
      .adc_finished(adc_finished), .measurement(measurement), .stopped(stopped),
      .detected(detected), .exhausted(exhausted), .step_count(step_count),
      .loop_count(loop_count), .last_meas(last_meas));
   always begin : monitor
      logic dac_q, adc_q;
      dac_q = 1'b0;
      adc_q = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (dac_arm && !dac_q) dac_rises++;
         if (adc_arm && !adc_q) adc_rises++;
         if (word_rst && !stopped) rst_pulses++;
         if (dac_arm && adc_arm) overlaps++;
         dac_q = dac_arm;
         adc_q = adc_arm;
      end
   end
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic bit sig(input int which);
      return (which == 0) ? word_next : (which == 1) ? dac_arm : adc_arm;
   endfunction
   task automatic wait_for(input int which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sig(which)) begin
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL timeout waiting for signal %0d: got 0 expected 1", which);
   endtask
   task automatic start(input int sp, input bit pol, input int conf, input int maxl, input int nw);
      setpoint = AW'(sp);
      polarity = pol;
      confirm_count = CW'(conf);
      max_loops = CW'(maxl);
      nwords = nw;
      widx = 0;
      arm = 1'b1;
      @(negedge clk);
   endtask
   task automatic present_word();
      if (word_rst) widx = 0;
      word = WBASE + DW'(widx);
      word_ok = 1'b1;
      word_last = (widx == nwords - 1);
      exp_dac.push_back({4'b0001, WBASE + DW'(widx)});
      @(negedge clk);
      word_ok = 1'b0;
      word_last = 1'b0;
      widx++;
   endtask
   task automatic do_step(input int m);
      bit ok;
      logic [DW+3:0] e;
      wait_for(0, ok);
      if (!ok) return;
      present_word();
      wait_for(1, ok);
      if (!ok) return;
      e = exp_dac.pop_front();
      check("dac_out", longint'(dac_out), longint'(e));
      dac_finished = 1'b1;
      @(negedge clk);
      dac_finished = 1'b0;
      wait_for(2, ok);
      if (!ok) return;
      measurement = AW'(m);
      adc_finished = 1'b1;
      @(negedge clk);
      adc_finished = 1'b0;
   endtask
   typedef struct {
      int sp; bit pol; int conf, maxl, nw, nsteps;
      int meas[8];
      bit det, exh; int step, loops, dacw, rsts, last;
   } vec_t;
   vec_t vecs[8];
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bit ok;
      int d0, a0, r0;
      logic [DW+3:0] e;
      vecs[0] = '{1000, 1'b1, 1, 2, 8, 16, '{500, 500, 500, 500, 500, 500, 500, 500}, 1'b0, 1'b1, 0, 2, 16, 2, 500};
      vecs[1] = '{1000, 1'b1, 3, 0, 8, 6, '{1200, 1200, 900, 1200, 1200, 1200, 0, 0}, 1'b1, 1'b0, 6, 0, 6, 0, 1200};
      vecs[2] = '{-50, 1'b0, 0, 0, 8, 1, '{-51, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 1, 0, 1, 0, -51};
      vecs[3] = '{100, 1'b1, 1, 0, 2, 2, '{0, 150, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 2, 0, 2, 0, 150};
      vecs[4] = '{0, 1'b1, 2, 0, 2, 3, '{-5, 5, 5, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 1, 1, 3, 1, 5};
      vecs[5] = '{0, 1'b1, 1, 1, 3, 3, '{-1, -1, -1, 0, 0, 0, 0, 0}, 1'b0, 1'b1, 0, 1, 3, 1, -1};
      vecs[6] = '{-50, 1'b0, 1, 0, 8, 2, '{-49, -50, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 2, 0, 2, 0, -50};
      vecs[7] = '{700, 1'b1, 1, 0, 8, 1, '{700, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 1, 0, 1, 0, 700};
      #3 rst_n = 1'b0;
      #1;
      check("rst_stopped", longint'(stopped), 1);
      check("rst_word_rst", longint'(word_rst), 1);
      check("rst_word_next", longint'(word_next), 0);
      check("rst_dac_arm", longint'(dac_arm), 0);
      check("rst_step_count", longint'(step_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (vecs[k]) begin
         d0 = dac_rises;
         r0 = rst_pulses;
         start(vecs[k].sp, vecs[k].pol, vecs[k].conf, vecs[k].maxl, vecs[k].nw);
         for (int s = 0; s < vecs[k].nsteps; s++) do_step(vecs[k].meas[s % 8]);
         @(negedge clk);
         check($sformatf("v%0d_detected", k), longint'(detected), longint'(vecs[k].det));
         check($sformatf("v%0d_exhausted", k), longint'(exhausted), longint'(vecs[k].exh));
         check($sformatf("v%0d_step_count", k), longint'(step_count), longint'(vecs[k].step));
         check($sformatf("v%0d_loop_count", k), longint'(loop_count), longint'(vecs[k].loops));
         check($sformatf("v%0d_last_meas", k), longint'(last_meas), longint'(vecs[k].last));
         check($sformatf("v%0d_dac_writes", k), longint'(dac_rises - d0), longint'(vecs[k].dacw));
         check($sformatf("v%0d_word_rst_pulses", k), longint'(rst_pulses - r0), longint'(vecs[k].rsts));
         check($sformatf("v%0d_stopped_run", k), longint'(stopped), 0);
         check($sformatf("v%0d_idle_handshakes", k), longint'({word_next, dac_arm, adc_arm}), 0);
         arm = 1'b0;
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_stopped_idle", k), longint'(stopped), 1);
         check($sformatf("v%0d_flags_cleared", k), longint'({detected, exhausted}), 0);
      end
      // arm dropped while the DAC handshake is open
      start(1000, 1'b1, 1, 0, 8);
      wait_for(0, ok);
      present_word();
      e = exp_dac.pop_front();
      check("abort_dac_out", longint'(dac_out), longint'(e));
      check("abort_dac_arm_up", longint'(dac_arm), 1);
      arm = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_dac_arm_held", longint'(dac_arm), 1);
      check("abort_not_stopped", longint'(stopped), 0);
      a0 = adc_rises;
      dac_finished = 1'b1;
      @(negedge clk);
      dac_finished = 1'b0;
      check("abort_dac_arm_done", longint'(dac_arm), 0);
      check("abort_stopped", longint'(stopped), 1);
      repeat (3) @(negedge clk);
      check("abort_no_adc_arm", longint'(adc_rises - a0), 0);
      // arm dropped while fetching
      start(1000, 1'b1, 1, 0, 8);
      wait_for(0, ok);
      arm = 1'b0;
      @(negedge clk);
      check("fetch_abort_stopped", longint'(stopped), 1);
      check("fetch_abort_word_next", longint'(word_next), 0);
      // asynchronous reset in the middle of the ADC handshake
      start(1000, 1'b1, 1, 0, 8);
      do_step(400);
      wait_for(0, ok);
      present_word();
      e = exp_dac.pop_front();
      check("mid_dac_out", longint'(dac_out), longint'(e));
      dac_finished = 1'b1;
      @(negedge clk);
      dac_finished = 1'b0;
      check("mid_adc_arm_up", longint'(adc_arm), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_stopped", longint'(stopped), 1);
      check("mid_rst_word_rst", longint'(word_rst), 1);
      check("mid_rst_adc_arm", longint'(adc_arm), 0);
      check("mid_rst_step_count", longint'(step_count), 0);
      check("mid_rst_dac_out", longint'(dac_out), 0);
      check("mid_rst_last_meas", longint'(last_meas), 0);
      arm = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      d0 = dac_rises;
      a0 = adc_rises;
      repeat (5) @(negedge clk);
      check("post_rst_no_arm_pulses", longint'((dac_rises - d0) + (adc_rises - a0)), 0);
      check("post_rst_stopped", longint'(stopped), 1);
      check("arm_overlap", longint'(overlaps), 0);
      check("scoreboard_empty", longint'(exp_dac.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
